// File: rtl/kgp_risc_pkg.sv
// Shared definitions for the KGP-RISC core: datapath widths, PC step and
// the fetch-stage state encoding.
package kgp_risc_pkg;

    localparam int INSTR_W = 32;
    localparam int PC_W    = 32;

    // Sequential PC step; 32'hFFFF_FFFC + PC_INC wraps to zero.
    localparam logic [PC_W-1:0] PC_INC = PC_W'(4);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        FLUSH = 2'd3
    } fetch_state_t;

    // Redirect targets are word addresses; the two low bits carry no meaning.
    function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] addr);
        return {addr[PC_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches one word at a time from
// instruction memory over req/ack and hands it to the decoder through a
// valid/ready output register. Redirects from execute replace the PC; a
// request that is already on the bus is completed and its data dropped.
module instruction_fetch_unit
    import kgp_risc_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr_out,
    output logic [PC_W-1:0]    pc_out,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc
);

    fetch_state_t       state_reg,  state_next;
    logic [PC_W-1:0]    pc_reg,     pc_next;
    logic [PC_W-1:0]    target_reg, target_next;
    logic               req_reg,    req_next;
    logic               valid_reg,  valid_next;
    logic [INSTR_W-1:0] instr_reg,  instr_next;
    logic [PC_W-1:0]    pc_out_reg, pc_out_next;
    logic [PC_W-1:0]    redirect_target;

    // The fetch address is the PC itself; while flushing the PC is left
    // untouched so the outstanding request keeps its address until ack.
    assign imem_req    = req_reg;
    assign imem_addr   = pc_reg;
    assign instr_valid = valid_reg;
    assign instr_out   = instr_reg;
    assign pc_out      = pc_out_reg;

    assign redirect_target = align_pc(redirect_pc);

    // Next-state logic: redirect first, then memory response, then decoder handshake.
    always_comb begin
        state_next  = state_reg;
        pc_next     = pc_reg;
        target_next = target_reg;
        valid_next  = valid_reg;
        instr_next  = instr_reg;
        pc_out_next = pc_out_reg;

        case (state_reg)
            IDLE: begin
                // Nothing is outstanding, so a redirect can take effect at once.
                state_next = REQ;
                valid_next = 1'b0;
                if (redirect_valid) begin
                    pc_next = redirect_target;
                end
            end

            REQ: begin
                if (redirect_valid) begin
                    if (imem_ack) begin
                        // Request retires this cycle: drop its data, refetch at target.
                        pc_next = redirect_target;
                    end else begin
                        // Request still outstanding: park the target, keep requesting.
                        target_next = redirect_target;
                        state_next  = FLUSH;
                    end
                end else if (imem_ack) begin
                    instr_next  = imem_rdata;
                    pc_out_next = pc_reg;
                    valid_next  = 1'b1;
                    pc_next     = pc_reg + PC_INC;
                    state_next  = WAIT;
                end
            end

            WAIT: begin
                if (redirect_valid) begin
                    // Held instruction is wrong-path even if the decoder takes it now.
                    pc_next    = redirect_target;
                    valid_next = 1'b0;
                    state_next = REQ;
                end else if (valid_reg && instr_ready) begin
                    valid_next = 1'b0;
                    state_next = REQ;
                end
            end

            FLUSH: begin
                // The newest redirect always wins, including one in the ack cycle.
                if (redirect_valid) begin
                    target_next = redirect_target;
                end
                if (imem_ack) begin
                    pc_next    = redirect_valid ? redirect_target : target_reg;
                    state_next = REQ;
                end
            end

            default: begin
                state_next = IDLE;
                valid_next = 1'b0;
            end
        endcase

        req_next = (state_next == REQ) || (state_next == FLUSH);
    end

    // State, PC, pending target and the registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            pc_reg     <= RESET_PC;
            target_reg <= RESET_PC;
            req_reg    <= 1'b0;
            valid_reg  <= 1'b0;
            instr_reg  <= '0;
            pc_out_reg <= '0;
        end else begin
            state_reg  <= state_next;
            pc_reg     <= pc_next;
            target_reg <= target_next;
            req_reg    <= req_next;
            valid_reg  <= valid_next;
            instr_reg  <= instr_next;
            pc_out_reg <= pc_out_next;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: a memory responder with a
// programmable ack latency, a per-cycle reference of the instruction stream
// the decoder must see, and directed scenarios with literal expectations.
module tb_instruction_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    int vectors    = 0;
    int miscompares = 0;
    int mem_lat    = 0;
    int mem_cnt    = 0;

    instruction_fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_out      (instr_out),
        .pc_out         (pc_out),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    always #5 clk = ~clk;

    // Memory contents as a function of address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #2;
    endtask

    task automatic smp;
        @(negedge clk);
    endtask

    // Memory responder: acks after mem_lat idle request cycles.
    initial begin
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (!imem_req) begin
                imem_ack   = 1'b0;
                imem_rdata = 32'hBAD0_BAD0;
                mem_cnt    = 0;
            end else if (mem_cnt >= mem_lat) begin
                imem_ack   = 1'b1;
                imem_rdata = mem_word(imem_addr);
                mem_cnt    = 0;
            end else begin
                imem_ack   = 1'b0;
                imem_rdata = 32'hBAD0_BAD0;
                mem_cnt++;
            end
        end
    end

    // Reference stream: the decoder must see consecutive words starting at
    // the reset PC or the latest redirect target, each exactly once.
    logic [31:0] exp_pc;
    logic        prev_pending;
    logic [31:0] prev_addr;

    // Per-cycle comparison of outputs against the reference and request rules.
    always @(negedge clk) begin
        if (rst) begin
            exp_pc       = RESET_PC;
            prev_pending = 1'b0;
            prev_addr    = 32'h0;
        end else begin
            if (prev_pending) begin
                chk("req_held", 32'(imem_req), 32'd1);
                chk("addr_held", imem_addr, prev_addr);
            end
            if (instr_valid) begin
                chk("model_pc", pc_out, exp_pc);
                chk("model_instr", instr_out, mem_word(pc_out));
            end
            prev_pending = imem_req && !imem_ack;
            prev_addr    = imem_addr;
            if (redirect_valid)
                exp_pc = {redirect_pc[31:2], 2'b00};
            else if (instr_valid && instr_ready)
                exp_pc = exp_pc + 32'd4;
        end
    end

    // Advance until the next cycle with instr_valid, then pin its contents.
    task automatic wait_valid(input string nm, input logic [31:0] epc, input logic [31:0] einstr);
        int n;
        n = 0;
        do begin
            step();
            smp();
            n++;
        end while (!instr_valid && n < 40);
        if (!instr_valid) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: instr_valid never rose within %0d cycles, expected pc %h", nm, n, epc);
        end else begin
            chk({nm, "_pc"}, pc_out, epc);
            chk({nm, "_instr"}, instr_out, einstr);
        end
    endtask

    // Expected values for the first six cycles after reset release.
    logic [31:0] t_req   [1:6] = '{1, 0, 1, 0, 1, 0};
    logic [31:0] t_addr  [1:6] = '{32'h0, 32'h0, 32'h4, 32'h0, 32'h8, 32'h0};
    logic [31:0] t_valid [1:6] = '{0, 1, 0, 1, 0, 1};
    logic [31:0] t_pc    [1:6] = '{32'h0, 32'h0, 32'h0, 32'h4, 32'h0, 32'h8};
    logic [31:0] t_instr [1:6] = '{32'h0, 32'hECA8_9BDF, 32'h0, 32'hECAC_9BDB, 32'h0, 32'hECA0_9BD7};

    initial begin
        rst            = 1'b1;
        instr_ready    = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        mem_lat        = 0;

        // Reset values
        repeat (3) step();
        smp();
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", imem_addr, RESET_PC);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr_out, 32'h0);
        chk("rst_pcout", pc_out, 32'h0);

        // Zero-wait fetch of 0x0, 0x4, 0x8 with a two-cycle spacing
        step();
        rst = 1'b0;
        smp();
        chk("first_cycle_req", 32'(imem_req), 32'd0);
        for (int i = 1; i <= 6; i++) begin
            step();
            smp();
            chk("seq_req", 32'(imem_req), t_req[i]);
            chk("seq_valid", 32'(instr_valid), t_valid[i]);
            if (imem_req) chk("seq_addr", imem_addr, t_addr[i]);
            if (instr_valid) begin
                chk("seq_pc", pc_out, t_pc[i]);
                chk("seq_instr", instr_out, t_instr[i]);
            end
        end

        // Ack on the third request cycle: address stable, valid one cycle after ack
        mem_lat = 2;
        for (int i = 0; i < 3; i++) begin
            step();
            if (i == 2) instr_ready = 1'b0;
            smp();
            chk("slow_req", 32'(imem_req), 32'd1);
            chk("slow_addr", imem_addr, 32'h0000_000C);
            chk("slow_ack", 32'(imem_ack), (i == 2) ? 32'd1 : 32'd0);
            chk("slow_valid", 32'(instr_valid), 32'd0);
        end

        // Decoder stalls for five cycles: output held, no new request
        for (int i = 0; i < 6; i++) begin
            step();
            if (i == 5) instr_ready = 1'b1;
            smp();
            chk("stall_valid", 32'(instr_valid), 32'd1);
            chk("stall_pc", pc_out, 32'h0000_000C);
            chk("stall_instr", instr_out, 32'hECA4_9BD3);
            chk("stall_req", 32'(imem_req), 32'd0);
        end
        step();
        smp();
        chk("after_stall_req", 32'(imem_req), 32'd1);
        chk("after_stall_addr", imem_addr, 32'h0000_0010);

        // Redirect to 0x103 while the request to 0x10 is pending
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        smp();
        chk("flush_ack0", 32'(imem_ack), 32'd0);
        chk("flush_addr0", imem_addr, 32'h0000_0010);
        step();
        redirect_valid = 1'b0;
        smp();
        chk("flush_req1", 32'(imem_req), 32'd1);
        chk("flush_addr1", imem_addr, 32'h0000_0010);
        chk("flush_ack1", 32'(imem_ack), 32'd1);
        step();
        smp();
        chk("flush_new_req", 32'(imem_req), 32'd1);
        chk("flush_new_addr", imem_addr, 32'h0000_0100);
        chk("flush_no_valid", 32'(instr_valid), 32'd0);
        wait_valid("redir103", 32'h0000_0100, 32'hEDA8_9ADF);
        mem_lat = 0;

        // Redirect in REQ in the same cycle as the ack
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0500;
        smp();
        chk("reqack_ack", 32'(imem_ack), 32'd1);
        chk("reqack_addr", imem_addr, 32'h0000_0104);
        step();
        redirect_valid = 1'b0;
        smp();
        chk("reqack_new_addr", imem_addr, 32'h0000_0500);
        chk("reqack_req", 32'(imem_req), 32'd1);
        chk("reqack_no_valid", 32'(instr_valid), 32'd0);
        wait_valid("redir500", 32'h0000_0500, mem_word(32'h0000_0500));

        // Redirect in WAIT with instr_ready=1, then two redirects in FLUSH
        step();
        smp();
        chk("wait_pre_addr", imem_addr, 32'h0000_0504);
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        mem_lat        = 3;
        smp();
        chk("wait_redir_valid", 32'(instr_valid), 32'd1);
        step();
        redirect_valid = 1'b0;
        smp();
        chk("wait_drop_valid", 32'(instr_valid), 32'd0);
        chk("wait_new_addr", imem_addr, 32'h0000_0200);
        chk("wait_new_req", 32'(imem_req), 32'd1);
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0300;
        smp();
        step();
        redirect_pc    = 32'h0000_0404;
        smp();
        chk("b2b_addr", imem_addr, 32'h0000_0200);
        step();
        redirect_valid = 1'b0;
        smp();
        chk("b2b_ack", 32'(imem_ack), 32'd1);
        chk("b2b_old_addr", imem_addr, 32'h0000_0200);
        step();
        smp();
        chk("b2b_last_wins", imem_addr, 32'h0000_0404);
        wait_valid("redir404", 32'h0000_0404, mem_word(32'h0000_0404));
        mem_lat = 0;

        // Redirect to the last word (low bits ignored): next fetch wraps to 0
        step();
        smp();
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFF;
        smp();
        step();
        redirect_valid = 1'b0;
        smp();
        chk("wrap_target_addr", imem_addr, 32'hFFFF_FFFC);
        wait_valid("wrap", 32'hFFFF_FFFC, 32'h1354_6423);
        step();
        smp();
        chk("wrap_next_req", 32'(imem_req), 32'd1);
        chk("wrap_next_addr", imem_addr, 32'h0000_0000);
        mem_lat = 10;

        // Reset asserted mid-request
        wait_valid("pre_rst", 32'h0000_0000, 32'hECA8_9BDF);
        step();
        smp();
        chk("midrst_req", 32'(imem_req), 32'd1);
        chk("midrst_addr", imem_addr, 32'h0000_0004);
        step();
        rst = 1'b1;
        smp();
        step();
        rst = 1'b0;
        smp();
        chk("midrst_req_drop", 32'(imem_req), 32'd0);
        chk("midrst_addr_rst", imem_addr, RESET_PC);
        chk("midrst_valid", 32'(instr_valid), 32'd0);
        chk("midrst_instr", instr_out, 32'h0);
        chk("midrst_pcout", pc_out, 32'h0);
        mem_lat = 0;
        wait_valid("post_rst", RESET_PC, 32'hECA8_9BDF);
        repeat (4) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Hard stop if the scenario sequence wedges.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, %0d miscompares so far", miscompares);
        $fatal(1);
    end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Front stage of the KGP-RISC core. Holds the program counter, fetches 32-bit instruction words from instruction memory over a req/ack handshake, and presents one instruction at a time, with its PC, to the instruction decoder through a valid/ready output register. Accepts taken-branch and jump redirects from the execute stage and flushes any wrong-path fetch.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset. Must be word-aligned.
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `imem_req`  out  1  fetch request to instruction memory.
- `imem_addr`  out  32  byte address of the word being fetched.
- `imem_ack`  in  1  memory response strobe; `imem_rdata` is valid in the same cycle.
- `imem_rdata`  in  32  fetched instruction word.
- `instr_valid`  out  1  `instr_out` and `pc_out` hold a live instruction.
- `instr_ready`  in  1  decoder accepts the instruction this cycle.
- `instr_out`  out  32  instruction word sent to the decoder.
- `pc_out`  out  32  address of `instr_out`.
- `redirect_valid`  in  1  execute stage orders a PC change.
- `redirect_pc`  in  32  new PC; bits [1:0] ignored and forced to 0.

## Operation
- States: IDLE, REQ, WAIT, FLUSH.
- IDLE: entered only on reset; always goes to REQ on the next cycle.
- REQ: `imem_req`=1, `imem_addr`=pc.
  - On ack: `instr_out`←rdata, `pc_out`←pc, `instr_valid`←1, pc←pc+4, then go to WAIT.
  - Without ack: stay in REQ.
- WAIT: `imem_req`=0. When `instr_valid`&&`instr_ready`: `instr_valid`←0, then go to REQ.
- FLUSH: `imem_req`=1, and `imem_addr` keeps the old address. On ack, the data is discarded and the block goes to REQ with the redirected pc.
- Request rule: once `imem_req` is raised, `imem_req` and `imem_addr` stay stable until `imem_ack`. A redirect never withdraws a pending request.
- Redirect has the highest priority. Its effect depends on the current state:
  - IDLE or WAIT: pc←target, `instr_valid`←0, go to REQ. A held instruction is dropped even if `instr_ready`=1 that cycle; the consumer must also drop it.
  - REQ with `imem_ack` in the same cycle: data discarded, pc←target, go to REQ.
  - REQ without ack: pc target stored, go to FLUSH, keep requesting the old address.
  - FLUSH: target overwritten by the newest redirect; the block stays in FLUSH.
- Arithmetic: the PC is 32 bits and increments by 4. 32'hFFFF_FFFC+4 wraps to 32'h0000_0000 without any flag.
- Output data never changes while `instr_valid`=1 and no redirect is present.

## Timing
- Reset values: `imem_req`=0, `imem_addr`=RESET_PC, `instr_valid`=0, `instr_out`=0, `pc_out`=0, pc=RESET_PC, state=IDLE.
- First `imem_req` is asserted in the 2nd cycle after `rst` deasserts.
- Latency from `imem_ack` to `instr_valid` is 1 cycle, because the outputs are registered.
- Peak throughput is one instruction per 2 cycles (zero-wait memory and `instr_ready` held at 1).
- Redirect to the first request for the new target:
  - 1 cycle from IDLE, WAIT, or REQ with an ack in the same cycle.
  - From FLUSH: the ack cycle of the old request + 1.
- Reset asserted mid-request: the request is dropped the next cycle. Any `imem_ack` arriving while in IDLE is ignored. The memory tolerates an abandoned request.

## Structure
- Shared package `kgp_risc_pkg` holds:
  - the fetch-state enum `fetch_state_t` (IDLE, REQ, WAIT, FLUSH);
  - `INSTR_W`=32, `PC_W`=32, `PC_INC`=4.
- Single module with no sub-modules. Pc, state, output register and pending-target logic fit in one always block plus next-state logic.

## Test plan
- Reset, zero-wait memory, `instr_ready`=1 → requests at 0x0, 0x4, 0x8. `pc_out` follows 0x0, 0x4, 0x8 with a 2-cycle spacing; `instr_out` equals the memory contents.
- Memory acks after 3 cycles → `imem_addr` is stable for all 3 cycles. `instr_valid` rises exactly 1 cycle after the ack.
- `instr_ready`=0 for 5 cycles while valid → `instr_out` and `pc_out` are held, with no new `imem_req`. The next request goes out after the ready cycle.
- Redirect to 0x103 during a pending request (ack after 2 cycles) → old data is discarded and never shown. The next `imem_addr` is 0x100, and `pc_out` becomes 0x100.
- Redirect in WAIT with `instr_ready`=1 → `instr_valid` becomes 0 the next cycle. The request goes to the target. Two back-to-back redirects in FLUSH → the last target wins.
- Redirect to 0xFFFF_FFFC → the next fetched address is 0x0. `rst` asserted mid-request → the next cycle shows all outputs at their reset values.
